operand_loader: RTL

OPERAND_LOADER -- requirements
Module: operand_loader

---
 rtl/operand_loader_if.sv | 25 ++
 rtl/operand_loader.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/operand_loader_if.sv
// Operand loader bus: serial load side from the upstream source plus the
// assembled operands and handshake toward the downstream adder register.
interface operand_loader_if #(parameter int n = 4);
   logic         start;
   logic         cin_in;
   logic         ser_in;
   logic         ser_valid;
   logic         ack;
   logic [n-1:0] a;
   logic [n-1:0] b;
   logic         c_in;
   logic         select;
   logic         busy;
   logic         err;

   modport master (
      output start, cin_in, ser_in, ser_valid, ack,
      input  a, b, c_in, select, busy, err
   );

   modport slave (
      input  start, cin_in, ser_in, ser_valid, ack,
      output a, b, c_in, select, busy, err
   );
endinterface

// File: rtl/operand_loader.sv
// Serial-to-parallel operand loader for an adder register: collects a then b LSB first.
// Optional per-operand even-parity check is enabled by defining OPERAND_PARITY_EN.
module operand_loader #(
   parameter int n = 4
) (
   input logic             clk,
   input logic             rst_n,
   operand_loader_if.slave bus
);

   localparam int CW = (n > 1) ? $clog2(n) : 1;
   localparam logic [CW-1:0] LAST_BIT = CW'(n - 1);

`ifdef OPERAND_PARITY_EN
   typedef enum logic [2:0] {
      IDLE,
      LOAD_A,
      PAR_A,
      LOAD_B,
      PAR_B,
      HOLD
   } state_t;
`else
   typedef enum logic [1:0] {
      IDLE,
      LOAD_A,
      LOAD_B,
      HOLD
   } state_t;
`endif

   state_t        state;
   logic [n-1:0]  a_q;
   logic [n-1:0]  b_q;
   logic [CW-1:0] cnt;
   logic          c_in_q;
   logic          select_q;
`ifdef OPERAND_PARITY_EN
   logic          err_q;
`endif

   // Single FSM; the counter only ever runs 0..n-1 and wraps on the last operand bit.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         cnt      <= '0;
         c_in_q   <= 1'b0;
         select_q <= 1'b0;
`ifdef OPERAND_PARITY_EN
         err_q    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (bus.start) begin
                  c_in_q <= bus.cin_in;
                  a_q    <= '0;
                  b_q    <= '0;
                  cnt    <= '0;
`ifdef OPERAND_PARITY_EN
                  err_q  <= 1'b0;
`endif
                  state  <= LOAD_A;
               end
            end

            LOAD_A: begin
               if (bus.ser_valid) begin
                  a_q <= {bus.ser_in, a_q[n-1:1]};
                  if (cnt == LAST_BIT) begin
                     cnt <= '0;
`ifdef OPERAND_PARITY_EN
                     state <= PAR_A;
`else
                     state <= LOAD_B;
`endif
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

`ifdef OPERAND_PARITY_EN
            // Even parity: the extra bit must equal the XOR of the operand bits.
            PAR_A: begin
               if (bus.ser_valid) begin
                  if (bus.ser_in == ^a_q) begin
                     state <= LOAD_B;
                  end else begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
`endif

            LOAD_B: begin
               if (bus.ser_valid) begin
                  b_q <= {bus.ser_in, b_q[n-1:1]};
                  if (cnt == LAST_BIT) begin
                     cnt <= '0;
`ifdef OPERAND_PARITY_EN
                     state <= PAR_B;
`else
                     state    <= HOLD;
                     select_q <= 1'b1;
`endif
                  end else begin
                     cnt <= cnt + CW'(1);
                  end
               end
            end

`ifdef OPERAND_PARITY_EN
            PAR_B: begin
               if (bus.ser_valid) begin
                  if (bus.ser_in == ^b_q) begin
                     state    <= HOLD;
                     select_q <= 1'b1;
                  end else begin
                     err_q <= 1'b1;
                     state <= IDLE;
                  end
               end
            end
`endif

            HOLD: begin
               if (bus.ack) begin
                  select_q <= 1'b0;
                  state    <= IDLE;
               end
            end

            default: begin
               state    <= IDLE;
               select_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.a      = a_q;
   assign bus.b      = b_q;
   assign bus.c_in   = c_in_q;
   assign bus.select = select_q;
   assign bus.busy   = (state != IDLE);
`ifdef OPERAND_PARITY_EN
   assign bus.err    = err_q;
`else
   assign bus.err    = 1'b0;
`endif

endmodule
